// File: rtl/pipe_stall_sequencer.sv
// pipe_stall_sequencer
// Front-end stall/flush sequencer for an in-order pipeline. The sequencer
// arbitrates data-cache back-pressure (memBusy), taken branches
// (branchTakenReq) and load-use hazards (loadUseReq) in that priority order.
// It drives the PC / IF_ID / DEC stage enables and the IF_ID / DEC bubble
// inserts.
//
// Outputs are Mealy: a request changes the outputs in the same cycle it is
// raised. A 3-bit down-counter stretches load stalls to LOAD_STALL_CYCLES
// cycles and branch flushes to BRANCH_FLUSH_CYCLES cycles. Both counts include
// the request cycle.
//
// Optional feature: define STALL_PERF_CNT_EN to build the two saturating
// 16-bit performance counters. When the macro is undefined, stallCycleCnt and
// flushEventCnt are tied to zero and no counter flops are built.

module pipe_stall_sequencer #(
    parameter int unsigned LOAD_STALL_CYCLES   = 1,  // 1..7
    parameter int unsigned BRANCH_FLUSH_CYCLES = 1   // 1..7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        loadUseReq,
    input  logic        branchTakenReq,
    input  logic        memBusy,
    output logic        PCLocker,
    output logic        IF_IDLocker,
    output logic        DECLocker,
    output logic        IF_IDFlush,
    output logic        DECFlush,
    output logic [1:0]  seqState,
    output logic [15:0] stallCycleCnt,
    output logic [15:0] flushEventCnt
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_e;

    // Counter reload values: cycles still to go after the request cycle.
    localparam logic [2:0] LOAD_RELOAD   = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] BRANCH_RELOAD = 3'(BRANCH_FLUSH_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    // Raw (ungated) stage controls; reset masking is applied at the ports.
    logic pc_lock, ifid_lock, dec_lock, ifid_flush, dec_flush;

    // State and down-counter register.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and Mealy output decode, priority memBusy > branch > load-use.
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_lock    = 1'b1;
        ifid_lock  = 1'b1;
        dec_lock   = 1'b1;
        ifid_flush = 1'b0;
        dec_flush  = 1'b0;

        if (memBusy) begin
            // Freeze the whole front end and drop any stall or flush in progress.
            pc_lock   = 1'b0;
            ifid_lock = 1'b0;
            dec_lock  = 1'b0;
            cnt_d     = 3'd0;
            state_d   = MEM_WAIT;
        end else begin
            unique case (state_q)
                MEM_WAIT: begin
                    // One run-out cycle. Pending requests are re-evaluated from RUN.
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end

                FLUSH: begin
                    ifid_flush = 1'b1;
                    dec_flush  = 1'b1;
                    if (branchTakenReq) begin
                        // A new redirect restarts the flush window.
                        cnt_d   = BRANCH_RELOAD;
                        state_d = (BRANCH_RELOAD != 3'd0) ? FLUSH : RUN;
                    end else if (cnt_q <= 3'd1) begin
                        // Last flush cycle; the counter never wraps below zero.
                        cnt_d   = 3'd0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end

                RUN, LOAD_STALL: begin
                    if (branchTakenReq) begin
                        ifid_flush = 1'b1;
                        dec_flush  = 1'b1;
                        cnt_d      = BRANCH_RELOAD;
                        state_d    = (BRANCH_RELOAD != 3'd0) ? FLUSH : RUN;
                    end else if (state_q == LOAD_STALL || loadUseReq) begin
                        // Hold PC and IF_ID and send a bubble down from DEC.
                        pc_lock   = 1'b0;
                        ifid_lock = 1'b0;
                        dec_flush = 1'b1;
                        if (state_q == RUN) begin
                            cnt_d   = LOAD_RELOAD;
                            state_d = (LOAD_RELOAD != 3'd0) ? LOAD_STALL : RUN;
                        end else if (cnt_q <= 3'd1) begin
                            cnt_d   = 3'd0;
                            state_d = RUN;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end

                default: begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // While reset is asserted every stage enable and bubble insert reads zero.
    assign PCLocker    = pc_lock    & rst_n;
    assign IF_IDLocker = ifid_lock  & rst_n;
    assign DECLocker   = dec_lock   & rst_n;
    assign IF_IDFlush  = ifid_flush & rst_n;
    assign DECFlush    = dec_flush  & rst_n;
    assign seqState    = state_q;

`ifdef STALL_PERF_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;
    logic        branch_accept;

    // A branch counts as a flush event only when it is accepted from RUN or
    // LOAD_STALL. A reload inside FLUSH extends the current event instead.
    assign branch_accept = !memBusy && branchTakenReq &&
                           (state_q == RUN || state_q == LOAD_STALL);

    // Saturating counters of frozen-PC cycles and accepted branches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (!pc_lock && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (branch_accept && flush_cnt_q != 16'hFFFF) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stallCycleCnt = stall_cnt_q;
    assign flushEventCnt = flush_cnt_q;
`else
    assign stallCycleCnt = 16'd0;
    assign flushEventCnt = 16'd0;
`endif

endmodule
